// File: rtl/multdiv_sequencer_if.sv
// multdiv_sequencer_if: request, multdiv-unit and result signals of the
// multiply/divide sequencer bundled into one interface.
//
// Handshake semantics: a request is offered by holding req_valid high with
// stable req_op/req_rd/op_a/op_b. The sequencer answers with stall while the
// operation is in flight. It releases stall in the single cycle that
// res_valid is high, and the pipeline advances on that edge. On the multdiv
// side, md_ctrl_mult/md_ctrl_div is a one-cycle start pulse. md_ready
// qualifies md_result/md_exception and is only honoured after the pulse
// cycle. flush overrides every other input in the cycle it is high.
interface multdiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_op;
   logic [4:0]       req_rd;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             flush;
   logic             stall;
   logic             busy;
   logic             md_ctrl_mult;
   logic             md_ctrl_div;
   logic [WIDTH-1:0] md_a;
   logic [WIDTH-1:0] md_b;
   logic [WIDTH-1:0] md_result;
   logic             md_exception;
   logic             md_ready;
   logic             res_valid;
   logic [WIDTH-1:0] res_data;
   logic [4:0]       res_rd;
   logic             res_exc;

   // Pipeline / multdiv side: drives requests and multdiv responses.
   modport master (
      output req_valid, req_op, req_rd, op_a, op_b, flush,
             md_result, md_exception, md_ready,
      input  stall, busy, md_ctrl_mult, md_ctrl_div, md_a, md_b,
             res_valid, res_data, res_rd, res_exc
   );

   // Sequencer side.
   modport slave (
      input  req_valid, req_op, req_rd, op_a, op_b, flush,
             md_result, md_exception, md_ready,
      output stall, busy, md_ctrl_mult, md_ctrl_div, md_a, md_b,
             res_valid, res_data, res_rd, res_exc
   );
endinterface

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: sequences the shared multi-cycle multiply/divide unit for
// the execute stage. It latches operands, pulses the start line once, stalls
// the pipeline until the result is ready, and then presents one result cycle.
// Exceptions are redirected to the status register.
// Optional feature: define MD_TIMEOUT_EN to abort a BUSY phase that lasts
// TIMEOUT cycles without md_ready (status TO_CODE).
module multdiv_sequencer #(
   parameter int WIDTH      = 32,
   parameter int TIMEOUT    = 40,
   parameter int MUL_CODE   = 4,
   parameter int DIV_CODE   = 5,
   parameter int TO_CODE    = 6,
   parameter int STATUS_REG = 30
) (
   input  logic                clock,
   input  logic                reset,
   multdiv_sequencer_if.slave  bus,
   output logic [1:0]          dbg_state_o,
   output logic [5:0]          dbg_cycles_o,
   output logic                dbg_timeout_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] K_MUL = 2'd0;
   localparam logic [1:0] K_DIV = 2'd1;
   localparam logic [1:0] K_TO  = 2'd2;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             op_q, op_d;
   logic [4:0]       rd_q, rd_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [4:0]       rdo_q, rdo_d;
   logic             exc_q, exc_d;
   logic             to_hit;

   // Status value written to STATUS_REG for each kind of abnormal completion.
   function automatic logic [WIDTH-1:0] status_code(input logic [1:0] kind);
      logic [WIDTH-1:0] code;
      case (kind)
         K_MUL:   code = WIDTH'(MUL_CODE);
         K_DIV:   code = WIDTH'(DIV_CODE);
         K_TO:    code = WIDTH'(TO_CODE);
         default: code = WIDTH'(TO_CODE);
      endcase
      return code;
   endfunction

   // The current BUSY cycle is the TIMEOUT-th one (counter cleared in ISSUE).
   assign to_hit = (state_q == BUSY) && ((int'(cnt_q) + 1) >= TIMEOUT);

   // State register, operand latches, cycle counter and result registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         rd_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         rdo_q   <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         rdo_q   <= rdo_d;
         exc_q   <= exc_d;
      end
   end

   // Next-state logic. Flush wins over req_valid and md_ready. md_ready is
   // only looked at in BUSY, so a stale ready from the previous op is ignored.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      rdo_d   = rdo_q;
      exc_d   = exc_q;
      if (bus.flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  a_d  = bus.op_a;
                  b_d  = bus.op_b;
                  op_d = bus.req_op;
                  rd_d = bus.req_rd;
                  if (bus.req_op && (bus.op_b == '0)) begin
                     // Divide by zero: report immediately, never start multdiv.
                     state_d = DONE;
                     data_d  = status_code(K_DIV);
                     rdo_d   = 5'(STATUS_REG);
                     exc_d   = 1'b1;
                  end else begin
                     state_d = ISSUE;
                  end
               end
            end
            ISSUE: begin
               cnt_d   = '0;
               state_d = BUSY;
            end
            BUSY: begin
               cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
               if (bus.md_ready) begin
                  state_d = DONE;
                  if (bus.md_exception) begin
                     data_d = status_code(op_q ? K_DIV : K_MUL);
                     rdo_d  = 5'(STATUS_REG);
                     exc_d  = 1'b1;
                  end else begin
                     data_d = bus.md_result;
                     rdo_d  = rd_q;
                     exc_d  = 1'b0;
                  end
               end
`ifdef MD_TIMEOUT_EN
               else if (to_hit) begin
                  state_d = DONE;
                  data_d  = status_code(K_TO);
                  rdo_d   = 5'(STATUS_REG);
                  exc_d   = 1'b1;
               end
`else
`endif
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Stall the pipeline while a request waits for completion. The pulse and
   // the result strobe are suppressed by a flush in the same cycle.
   assign bus.stall        = bus.req_valid & (state_q != DONE) & ~bus.flush;
   assign bus.busy         = (state_q != IDLE);
   assign bus.md_ctrl_mult = (state_q == ISSUE) & ~op_q & ~bus.flush;
   assign bus.md_ctrl_div  = (state_q == ISSUE) &  op_q & ~bus.flush;
   assign bus.md_a         = a_q;
   assign bus.md_b         = b_q;
   assign bus.res_valid    = (state_q == DONE) & ~bus.flush;
   assign bus.res_data     = data_q;
   assign bus.res_rd       = rdo_q;
   assign bus.res_exc      = exc_q;

   assign dbg_state_o   = state_q;
   assign dbg_cycles_o  = cnt_q;
   assign dbg_timeout_o = to_hit;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed test of multdiv_sequencer. The driver tasks
// play both the execute stage and the multdiv unit. Expected results are
// queued when a request is issued, and a negedge monitor pops and compares
// them on every res_valid.
module tb_multdiv_sequencer;
   localparam int W = 32;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] dbg_state;
   logic [5:0] dbg_cycles;
   logic       dbg_timeout;

   int n_checks   = 0;
   int n_fail     = 0;
   int mul_pulses = 0;
   int div_pulses = 0;
   int stall_cnt  = 0;
   int res_cnt    = 0;
   int n_pushed   = 0;

   logic [W+5:0] exp_q[$];

   multdiv_sequencer_if #(.WIDTH(W)) bus ();

   multdiv_sequencer #(
      .WIDTH(W), .TIMEOUT(40), .MUL_CODE(4), .DIV_CODE(5), .TO_CODE(6), .STATUS_REG(30)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .bus           (bus),
      .dbg_state_o   (dbg_state),
      .dbg_cycles_o  (dbg_cycles),
      .dbg_timeout_o (dbg_timeout)
   );

   // Clock and watchdog.
   always #5 clock = ~clock;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required test completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Monitor: pulse/stall bookkeeping and scoreboard comparison on res_valid.
   always @(negedge clock) begin
      if (!reset) begin
         if (bus.md_ctrl_mult) mul_pulses++;
         if (bus.md_ctrl_div)  div_pulses++;
         if (bus.stall)        stall_cnt++;
         if (bus.md_ctrl_mult && bus.md_ctrl_div) begin
            n_checks++;
            n_fail++;
            $display("FAIL dual_pulse: got mult=1 div=1, required at most one");
         end
         if (bus.res_valid) begin
            logic [W+5:0] e;
            res_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_res: got res_valid with data %0d, required none", bus.res_data);
            end else begin
               e = exp_q.pop_front();
               check("res_data", 64'(bus.res_data), 64'(e[W+5:6]));
               check("res_rd",   64'(bus.res_rd),   64'(e[5:1]));
               check("res_exc",  64'(bus.res_exc),  64'(e[0]));
            end
         end
      end
   end

   // Driver tasks.
   task automatic drive_req(input logic op, input logic [4:0] rd, input logic [W-1:0] a,
                            input logic [W-1:0] b);
      @(posedge clock); #1;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_rd    = rd;
      bus.op_a      = a;
      bus.op_b      = b;
      stall_cnt     = 0;
   endtask

   task automatic wait_pulse(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (bus.md_ctrl_mult || bus.md_ctrl_div) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL pulse_wait: got no start pulse in 8 cycles, required one");
      end
   endtask

   // Multdiv model: drop stale ready once ISSUE is over, then answer d cycles
   // (d >= 1) after the pulse.
   task automatic return_ready(input int d, input logic [W-1:0] r, input logic e);
      @(posedge clock); #1;
      bus.md_ready = 1'b0;
      if (d > 1) begin
         repeat (d - 1) @(posedge clock);
         #1;
      end
      bus.md_ready     = 1'b1;
      bus.md_result    = r;
      bus.md_exception = e;
   endtask

   task automatic wait_res(input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clock);
         if (bus.res_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL res_wait: got no res_valid in %0d cycles, required one", limit);
      end
   endtask

   task automatic end_req(input bit keep_ready);
      @(posedge clock); #1;
      bus.req_valid    = 1'b0;
      bus.md_exception = 1'b0;
      if (!keep_ready) bus.md_ready = 1'b0;
   endtask

   task automatic run_op(input logic op, input logic [4:0] rd, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit issue, input int d,
                         input logic [W-1:0] r, input logic e,
                         input logic [W-1:0] x_data, input logic [4:0] x_rd, input logic x_exc,
                         input int x_stall, input bit keep_ready);
      int m0;
      int d0;
      bit seen;
      m0 = mul_pulses;
      d0 = div_pulses;
      exp_q.push_back({x_data, x_rd, x_exc});
      n_pushed++;
      drive_req(op, rd, a, b);
      if (issue) begin
         wait_pulse(seen);
         if (seen) begin
            check("md_a", 64'(bus.md_a), 64'(a));
            check("md_b", 64'(bus.md_b), 64'(b));
            return_ready(d, r, e);
         end
      end
      wait_res(100);
      end_req(keep_ready);
      check("stall_cycles", 64'(stall_cnt), 64'(x_stall));
      check("mul_pulses", 64'(mul_pulses - m0), 64'(issue && !op));
      check("div_pulses", 64'(div_pulses - d0), 64'(issue && op));
   endtask

   // Stimulus.
   initial begin
      int  r0;
      int  p0;
      bit  seen;
      bus.req_valid    = 1'b0;
      bus.req_op       = 1'b0;
      bus.req_rd       = '0;
      bus.op_a         = '0;
      bus.op_b         = '0;
      bus.flush        = 1'b0;
      bus.md_result    = '0;
      bus.md_exception = 1'b0;
      bus.md_ready     = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state.
      @(negedge clock);
      check("rst_busy",     64'(bus.busy),      64'd0);
      check("rst_stall",    64'(bus.stall),     64'd0);
      check("rst_resvalid", 64'(bus.res_valid), 64'd0);
      check("rst_resdata",  64'(bus.res_data),  64'd0);
      check("rst_resrd",    64'(bus.res_rd),    64'd0);
      check("rst_resexc",   64'(bus.res_exc),   64'd0);
      check("rst_md_a",     64'(bus.md_a),      64'd0);
      check("rst_state",    64'(dbg_state),     64'd0);

      // mul 7*6, ready 17 cycles after the pulse.
      run_op(1'b0, 5'd5, 32'd7, 32'd6, 1'b1, 17, 32'd42, 1'b0, 32'd42, 5'd5, 1'b0, 19, 1'b0);
      // div 100/0: no pulse, one stall cycle, status redirect.
      run_op(1'b1, 5'd9, 32'd100, 32'd0, 1'b0, 0, 32'd0, 1'b0, 32'd5, 5'd30, 1'b1, 1, 1'b0);
      // mul with exception at ready.
      run_op(1'b0, 5'd12, 32'd123, 32'd456, 1'b1, 3, 32'hdead, 1'b1, 32'd4, 5'd30, 1'b1, 5, 1'b0);

      // Flush in BUSY, then a late md_ready in IDLE.
      r0 = res_cnt;
      drive_req(1'b0, 5'd7, 32'd5, 32'd5);
      wait_pulse(seen);
      @(posedge clock); #1;
      repeat (5) @(posedge clock);
      #1;
      bus.flush = 1'b1;
      @(negedge clock);
      check("flush_stall", 64'(bus.stall), 64'd0);
      @(posedge clock); #1;
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      p0 = mul_pulses + div_pulses;
      repeat (2) @(posedge clock);
      #1;
      bus.md_ready  = 1'b1;
      bus.md_result = 32'd25;
      @(posedge clock); #1;
      bus.md_ready = 1'b0;
      repeat (3) @(negedge clock);
      check("flush_busy",   64'(bus.busy),                 64'd0);
      check("flush_stall2", 64'(bus.stall),                64'd0);
      check("flush_state",  64'(dbg_state),                64'd0);
      check("flush_nores",  64'(res_cnt - r0),             64'd0);
      check("flush_nopuls", 64'(mul_pulses + div_pulses - p0), 64'd0);

      // Back-to-back divs; ready left high from the first must be ignored.
      run_op(1'b1, 5'd3, 32'd84, 32'd2, 1'b1, 2, 32'd42, 1'b0, 32'd42, 5'd3, 1'b0, 4, 1'b1);
      run_op(1'b1, 5'd4, 32'd9,  32'd3, 1'b1, 4, 32'd3,  1'b0, 32'd3,  5'd4, 1'b0, 6, 1'b0);

      // Flush arriving in DONE suppresses res_valid; result registers hold.
      r0 = res_cnt;
      drive_req(1'b0, 5'd8, 32'd2, 32'd3);
      wait_pulse(seen);
      return_ready(2, 32'd6, 1'b0);
      @(posedge clock); #1;
      bus.flush = 1'b1;
      @(negedge clock);
      check("dflush_resvalid", 64'(bus.res_valid), 64'd0);
      check("dflush_stall",    64'(bus.stall),     64'd0);
      @(posedge clock); #1;
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      bus.md_ready  = 1'b0;
      @(negedge clock);
      check("dflush_nores", 64'(res_cnt - r0),  64'd0);
      check("dflush_busy",  64'(bus.busy),      64'd0);
      check("dflush_hold",  64'(bus.res_data),  64'd6);
      check("dflush_holdrd", 64'(bus.res_rd),   64'd8);

      // Reset in the middle of an operation clears results and latches.
      drive_req(1'b0, 5'd10, 32'd9, 32'd9);
      wait_pulse(seen);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      @(negedge clock);
      check("mrst_busy",    64'(bus.busy),     64'd0);
      check("mrst_resdata", 64'(bus.res_data), 64'd0);
      check("mrst_resrd",   64'(bus.res_rd),   64'd0);
      check("mrst_resexc",  64'(bus.res_exc),  64'd0);
      check("mrst_md_a",    64'(bus.md_a),     64'd0);
      check("mrst_md_b",    64'(bus.md_b),     64'd0);

      // md_ready never arrives.
`ifdef MD_TIMEOUT_EN
      exp_q.push_back({32'd6, 5'd30, 1'b1});
      n_pushed++;
      drive_req(1'b0, 5'd11, 32'd3, 32'd4);
      wait_pulse(seen);
      @(posedge clock); #1;
      bus.md_ready = 1'b0;
      wait_res(100);
      end_req(1'b0);
      check("to_stall_cycles", 64'(stall_cnt), 64'd42);
`else
      r0 = res_cnt;
      drive_req(1'b0, 5'd11, 32'd3, 32'd4);
      wait_pulse(seen);
      @(posedge clock); #1;
      bus.md_ready = 1'b0;
      repeat (80) @(posedge clock);
      @(negedge clock);
      check("hang_stall",   64'(bus.stall),    64'd1);
      check("hang_busy",    64'(bus.busy),     64'd1);
      check("hang_state",   64'(dbg_state),    64'd2);
      check("hang_cycles",  64'(dbg_cycles),   64'd63);
      check("hang_tohit",   64'(dbg_timeout),  64'd1);
      check("hang_nores",   64'(res_cnt - r0), 64'd0);
      @(posedge clock); #1;
      bus.flush = 1'b1;
      @(posedge clock); #1;
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      @(negedge clock);
      check("hang_recover", 64'(bus.busy), 64'd0);
`endif

      // Final report.
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("sb_empty",   64'(exp_q.size()), 64'd0);
      check("res_total",  64'(res_cnt),      64'(n_pushed));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
